// File: rtl/cmd_frame_tx.sv
// Response-frame transmitter: serialises FE, L=N+2, CMD, N payload bytes, EF
// onto a byte-wide valid/ready UART Tx port, pulling payload from a FWFT FIFO.
module cmd_frame_tx #(
  parameter logic [7:0] HDR_BYTE = 8'hFE,
  parameter logic [7:0] EOF_BYTE = 8'hEF,
  parameter int         N_W      = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [7:0]     cmd_code,
  input  logic [N_W-1:0] N_input,
  input  logic [7:0]     fifo_data,
  input  logic           fifo_empty,
  output logic           fifo_rd,
  output logic [7:0]     tx_data,
  output logic           tx_valid,
  input  logic           tx_ready,
  output logic           busy,
  output logic           frame_done
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_HDR,
    S_LEN,
    S_CMD,
    S_PAYLOAD,
    S_EOF,
    S_DONE
  } state_t;

  state_t         state;
  state_t         state_nxt;
  logic [7:0]     cmd_q;
  logic [N_W-1:0] n_q;
  logic [N_W-1:0] cnt;
  logic           payload_xfer;

  assign payload_xfer = (state == S_PAYLOAD) && !fifo_empty && tx_ready;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= S_IDLE;
      cmd_q <= '0;
      n_q   <= '0;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      if (state == S_IDLE && start) begin
        cmd_q <= cmd_code;
        n_q   <= N_input;
        cnt   <= '0;
      end else if (payload_xfer) begin
        cnt <= cnt + N_W'(1);
      end
    end
  end

  // NOTE: every output and the next state get a default first, so no path
  // through the case statement can leave a value unassigned and infer a latch.
  always_comb begin
    state_nxt  = state;
    tx_data    = '0;
    tx_valid   = 1'b0;
    fifo_rd    = 1'b0;
    busy       = 1'b1;
    frame_done = 1'b0;
    unique case (state)
      S_IDLE: begin
        busy = 1'b0;
        if (start) state_nxt = S_HDR;
      end
      S_HDR: begin
        tx_data  = HDR_BYTE;
        tx_valid = 1'b1;
        if (tx_ready) state_nxt = S_LEN;
      end
      S_LEN: begin
        // L counts CMD and EOF as well as the payload, matching host frames.
        tx_data  = 8'(n_q) + 8'd2;
        tx_valid = 1'b1;
        if (tx_ready) state_nxt = S_LEN == state ? S_CMD : state;
      end
      S_CMD: begin
        tx_data  = cmd_q;
        tx_valid = 1'b1;
        if (tx_ready) state_nxt = (n_q != '0) ? S_PAYLOAD : S_EOF;
      end
      S_PAYLOAD: begin
        tx_data  = fifo_data;
        tx_valid = !fifo_empty;
        fifo_rd  = payload_xfer;
        if (payload_xfer && cnt == n_q - N_W'(1)) state_nxt = S_EOF;
      end
      S_EOF: begin
        tx_data  = EOF_BYTE;
        tx_valid = 1'b1;
        if (tx_ready) state_nxt = S_DONE;
      end
      S_DONE: begin
        busy       = 1'b0;
        frame_done = 1'b1;
        state_nxt  = S_IDLE;
      end
      default: begin
        busy      = 1'b0;
        state_nxt = S_IDLE;
      end
    endcase
  end

endmodule
